// File: rtl/sync_fifo_prog_if.sv
// Handshake and status bundle for sync_fifo_prog.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_prog_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             winc;
  logic [WIDTH-1:0] wdata;
  logic             rinc;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             wfull;
  logic             rempty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wdata, rinc,
    input  rdata, rvalid, wfull, rempty,
    input  almost_full, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, rvalid, wfull, rempty,
    output almost_full, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost flags,
// sticky over/underflow and optional first-word-fall-through.
module sync_fifo_prog #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_prog_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    cnt;
  logic             ov;
  logic             uf;
  logic             full;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;

  // Extra pointer MSB tells a full ring from an empty one.
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign wr_ok = bus.winc && !full;
  assign rd_ok = bus.rinc && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ov   <= 1'b0;
      uf   <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      if (rd_ok) rptr <= rptr + PW'(1);
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + PW'(1);
        2'b01:   cnt <= cnt - PW'(1);
        default: cnt <= cnt;
      endcase
      if (bus.winc && full)  ov <= 1'b1;
      if (bus.rinc && empty) uf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wptr[AW-1:0]] <= bus.wdata;
  end

  assign bus.wfull        = full;
  assign bus.rempty       = empty;
  assign bus.almost_full  = (cnt >= PW'(AF_LEVEL));
  assign bus.almost_empty = (cnt <= PW'(AE_LEVEL));
  assign bus.count        = cnt;
  assign bus.overflow     = ov;
  assign bus.underflow    = uf;

  if (FWFT != 0) begin : g_fwft
    assign bus.rdata  = empty ? '0 : mem[rptr[AW-1:0]];
    assign bus.rvalid = !empty;
  end else begin : g_std
    logic [WIDTH-1:0] rd_q;
    logic             rv_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= '0;
        rv_q <= 1'b0;
      end else begin
        rv_q <= rd_ok;
        if (rd_ok) rd_q <= mem[rptr[AW-1:0]];
      end
    end

    assign bus.rdata  = rd_q;
    assign bus.rvalid = rv_q;
  end
endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, WIDTH >= 1.
REQ-002 SHALL have parameter DEPTH, default 16: storage entries, power of two, DEPTH >= 4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full threshold, 1 <= AF_LEVEL <= DEPTH-1.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty threshold, 1 <= AE_LEVEL <= DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0: 0 = standard read (1-cycle latency), 1 = first-word-fall-through.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port winc, input, 1 bit: write request.
REQ-009 SHALL have port wdata, input, WIDTH bits: write data.
REQ-010 SHALL have port rinc, input, 1 bit: read request (pop).
REQ-011 SHALL have port rdata, output, WIDTH bits: read data.
REQ-012 SHALL have port rvalid, output, 1 bit: rdata holds a valid popped word (standard mode) or valid head word (FWFT).
REQ-013 SHALL have port wfull, output, 1 bit: count == DEPTH.
REQ-014 SHALL have port rempty, output, 1 bit: count == 0.
REQ-015 SHALL have port almost_full, output, 1 bit: count >= AF_LEVEL.
REQ-016 SHALL have port almost_empty, output, 1 bit: count <= AE_LEVEL.
REQ-017 SHALL have port count, output, $clog2(DEPTH)+1 bits: stored words.
REQ-018 SHALL have port overflow, output, 1 bit: sticky, rejected write seen.
REQ-019 SHALL have port underflow, output, 1 bit: sticky, rejected read seen.

Function
REQ-020 SHALL accept a write only when winc && !wfull; the word is stored at waddr and waddr increments modulo DEPTH.
REQ-021 SHALL accept a read only when rinc && !rempty; raddr increments modulo DEPTH.
REQ-022 SHALL use pointers of $clog2(DEPTH)+1 bits; full = MSBs differ and lower bits equal, empty = pointers equal.
REQ-023 SHALL update count by +1 (write only), -1 (read only), 0 (both or neither accepted) each edge.
REQ-024 SHALL derive wfull, rempty, almost_full, almost_empty from registered state so that they reflect the new count in the cycle after the edge.
REQ-025 SHALL, when full, accept a simultaneous read and reject the write (count -> DEPTH-1, overflow set).
REQ-026 SHALL, when empty, accept a simultaneous write and reject the read (count -> 1, underflow set); no data bypass.
REQ-027 SHALL, in FWFT=0, register the popped word onto rdata one cycle after the accepted read, pulse rvalid high for that cycle, and hold rdata otherwise.
REQ-028 SHALL, in FWFT=1, present the head word on rdata with rvalid = !rempty; an accepted read advances rdata to the next word on the following cycle.
REQ-029 SHALL set overflow on winc && wfull and underflow on rinc && rempty; both remain set until reset.
REQ-030 SHALL never corrupt stored data or pointers on a rejected request.
REQ-031 SHALL wrap pointers through 2*DEPTH without any flag glitch.

Reset
REQ-032 SHALL, on rst high, asynchronously clear pointers, count, rdata, rvalid, overflow, underflow.
REQ-033 SHALL drive during/after reset: rempty=1, almost_empty=1, wfull=0, almost_full=0, count=0.
REQ-034 SHALL discard all contents on reset asserted mid-operation; storage array need not be cleared.
REQ-035 SHALL ignore winc/rinc while rst is high; first accepted operation on the first edge after rst falls.

Verification (DEPTH=16, WIDTH=8, AF_LEVEL=14, AE_LEVEL=2)
REQ-036 SHALL cover: write 0x00..0x0F, FWFT=0 -> wfull=1 after 16th edge, almost_full from count 14, then 16 reads return 0x00..0x0F in order, rvalid one cycle after each rinc.
REQ-037 SHALL cover: full FIFO, winc=1 with 0xAA -> write rejected, overflow=1, count stays 16, later reads never return 0xAA.
REQ-038 SHALL cover: empty FIFO, winc=1 wdata=0x55 and rinc=1 same edge -> count=1, underflow=1, next read returns 0x55.
REQ-039 SHALL cover: full FIFO, winc and rinc same edge -> count=15, wfull=0, overflow=1, head popped.
REQ-040 SHALL cover: FWFT=1, single write 0x3C -> rdata=0x3C and rvalid=1 with rinc low; rinc pops and rvalid drops.
REQ-041 SHALL cover: 40 writes/reads interleaved (wrap), then rst pulse mid-stream -> count=0, rempty=1, flags cleared immediately, no cycle wait.
